// File: rtl/note_hit_judge.sv
// note_hit_judge
//   Judges one rhythm-game lane. The raw player button is synchronized and
//   debounced into a single press strobe. The lane's hit-zone bit is
//   edge-detected into note_enter / note_exit. A three-state FSM classifies
//   each press or note departure as HIT, MISS or STRAY. It keeps a saturating
//   score and combo, and drives a timed feedback colour.
//
// Parameters
//   DEBOUNCE_CYCLES  cycles the synchronized button must hold a new level
//   FLASH_CYCLES     cycles a judgement colour stays on judge_rgb
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   zone_note    1 = a note occupies the hit zone
//   button       raw asynchronous button, active-low (0 = pressed)
//   score        accumulated score, saturates at 65535
//   combo        consecutive hits, saturates at 255
//   hit_pulse    one-cycle HIT strobe
//   miss_pulse   one-cycle MISS strobe
//   stray_pulse  one-cycle STRAY strobe (press with no note)
//   judge_rgb    feedback colour: green after a hit, red after a miss or stray

module note_hit_judge #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FLASH_CYCLES    = 6250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        zone_note,
  input  logic        button,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic        stray_pulse,
  output logic [5:0]  judge_rgb
);

  // The counters only ever count up to N-1, so $clog2(N) bits are enough.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FL_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FL_W-1:0] FLASH_LOAD = FL_W'(FLASH_CYCLES - 1);
  localparam logic [5:0] RGB_GREEN = 6'b001100;
  localparam logic [5:0] RGB_RED   = 6'b110000;
  localparam logic [5:0] RGB_OFF   = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_JUDGED = 2'd2
  } state_t;

  logic            sync1_q, sync2_q;
  logic            db_level_q, db_level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press_q, press_d;
  logic            zone_prev_q;
  logic            note_enter_s, note_exit_s;
  state_t          state_q, state_d;
  logic            hit_s, miss_s, stray_s;
  logic [15:0]     score_q, score_d;
  logic [7:0]      combo_q, combo_d;
  logic [16:0]     score_sum_s;
  logic            hit_q, miss_q, stray_q;
  logic [5:0]      rgb_q, rgb_d;
  logic [FL_W-1:0] flash_q, flash_d;

  // Two-flop synchronizer; resets to the released level so reset never
  // manufactures a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive
  // mismatching cycles. The press strobe fires only on the accepted 1->0 edge.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = {DB_W{1'b0}};
    press_d    = 1'b0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync2_q;
        press_d    = ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = {DB_W{1'b0}};
    end
  end

  // Debounce and zone-edge registers
  always_ff @(posedge clk) begin
    if (reset) begin
      db_level_q  <= 1'b1;
      db_cnt_q    <= {DB_W{1'b0}};
      press_q     <= 1'b0;
      zone_prev_q <= 1'b0;
    end else begin
      db_level_q  <= db_level_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      zone_prev_q <= zone_note;
    end
  end

  // zone_prev clears on reset, so a note still present as reset is released
  // shows up as a fresh note_enter.
  assign note_enter_s = zone_note & ~zone_prev_q;
  assign note_exit_s  = ~zone_note & zone_prev_q;

  // Judging FSM next state and event decode
  always_comb begin
    state_d = state_q;
    hit_s   = 1'b0;
    miss_s  = 1'b0;
    stray_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (note_enter_s) begin
          if (press_q) begin
            hit_s   = 1'b1;
            state_d = ST_JUDGED;
          end else begin
            state_d = ST_ARMED;
          end
        end else if (press_q) begin
          stray_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (press_q) begin
          // The press wins over a same-cycle exit; the note is gone, so go idle.
          hit_s   = 1'b1;
          state_d = note_exit_s ? ST_IDLE : ST_JUDGED;
        end else if (note_exit_s) begin
          miss_s  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_JUDGED: begin
        if (note_exit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_JUDGED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Score and combo update; the bonus depends on the combo before this hit.
  always_comb begin
    score_d     = score_q;
    combo_d     = combo_q;
    score_sum_s = {1'b0, score_q} + ((combo_q >= 8'd10) ? 17'd20 : 17'd10);
    if (hit_s) begin
      score_d = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
      combo_d = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
    end else if (miss_s || stray_s) begin
      combo_d = 8'd0;
    end else begin
      combo_d = combo_q;
    end
  end

  // Flash colour: an event loads the timer and colour. The timer then counts
  // down to zero and stops, and the colour clears on the following cycle.
  always_comb begin
    rgb_d   = rgb_q;
    flash_d = flash_q;
    if (hit_s) begin
      rgb_d   = RGB_GREEN;
      flash_d = FLASH_LOAD;
    end else if (miss_s || stray_s) begin
      rgb_d   = RGB_RED;
      flash_d = FLASH_LOAD;
    end else if (flash_q != {FL_W{1'b0}}) begin
      flash_d = flash_q - FL_W'(1);
    end else begin
      rgb_d = RGB_OFF;
    end
  end

  // FSM, score, pulse and flash registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      score_q <= 16'd0;
      combo_q <= 8'd0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      stray_q <= 1'b0;
      rgb_q   <= RGB_OFF;
      flash_q <= {FL_W{1'b0}};
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      combo_q <= combo_d;
      hit_q   <= hit_s;
      miss_q  <= miss_s;
      stray_q <= stray_s;
      rgb_q   <= rgb_d;
      flash_q <= flash_d;
    end
  end

  assign score       = score_q;
  assign combo       = combo_q;
  assign hit_pulse   = hit_q;
  assign miss_pulse  = miss_q;
  assign stray_pulse = stray_q;
  assign judge_rgb   = rgb_q;

endmodule

// File: tb/tb_note_hit_judge.sv
// Directed self-checking bench for note_hit_judge with DEBOUNCE_CYCLES=4 and
// FLASH_CYCLES=8. Inputs are driven 1 time unit after each rising edge, and
// outputs are sampled at the same point.

module tb_note_hit_judge;

  logic        clk = 1'b0;
  logic        reset;
  logic        zone_note;
  logic        button;
  logic [15:0] score;
  logic [7:0]  combo;
  logic        hit_pulse, miss_pulse, stray_pulse;
  logic [5:0]  judge_rgb;

  int total = 0;
  int bad   = 0;
  int n_hit, n_miss, n_stray, n_multi, n_green, n_red;

  always #5 clk = ~clk;

  note_hit_judge #(
    .DEBOUNCE_CYCLES(4),
    .FLASH_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .zone_note(zone_note),
    .button(button),
    .score(score),
    .combo(combo),
    .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse),
    .stray_pulse(stray_pulse),
    .judge_rgb(judge_rgb)
  );

  task automatic clear_counts();
    n_hit = 0; n_miss = 0; n_stray = 0; n_multi = 0; n_green = 0; n_red = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    n_hit   += int'(hit_pulse);
    n_miss  += int'(miss_pulse);
    n_stray += int'(stray_pulse);
    if ((int'(hit_pulse) + int'(miss_pulse) + int'(stray_pulse)) > 1) n_multi++;
    if (judge_rgb == 6'b001100) n_green++;
    if (judge_rgb == 6'b110000) n_red++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1; zone_note = 1'b0; button = 1'b1;
    run(4);
    reset = 1'b0;
    run(4);
    clear_counts();
  endtask

  // One hit from idle: note and press start together, then note and button
  // are released long enough for the release to debounce.
  task automatic hit_fast();
    int seen;
    seen = 0;
    zone_note = 1'b1; button = 1'b0;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      cyc();
      if (hit_pulse) seen = 1;
    end
    total++;
    if (seen == 0) begin bad++; $display("FAIL hit_fast_timeout got=0 want=1"); end
    zone_note = 1'b0; button = 1'b1;
    run(6);
  endtask

  task automatic test_reset();
    reset = 1'b1; zone_note = 1'b0; button = 1'b0;
    run(3);
    total++; if (score !== 16'd0) begin bad++; $display("FAIL reset_score got=%0d want=0", score); end
    total++; if (combo !== 8'd0) begin bad++; $display("FAIL reset_combo got=%0d want=0", combo); end
    total++; if ({hit_pulse, miss_pulse, stray_pulse} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {hit_pulse, miss_pulse, stray_pulse}); end
    total++; if (judge_rgb !== 6'b000000) begin bad++; $display("FAIL reset_rgb got=%b want=000000", judge_rgb); end
    clear_counts();
    button = 1'b1; reset = 1'b0;
    run(8);
    total++; if (n_stray != 0) begin bad++; $display("FAIL reset_no_press got=%0d want=0", n_stray); end
  endtask

  task automatic test_basic_hit();
    do_reset();
    for (int i = 0; i < 45; i++) begin
      zone_note = (i < 35);
      button    = !(i >= 5 && i < 15);
      cyc();
    end
    total++; if (n_hit != 1) begin bad++; $display("FAIL basic_hits got=%0d want=1", n_hit); end
    total++; if (score !== 16'd10) begin bad++; $display("FAIL basic_score got=%0d want=10", score); end
    total++; if (combo !== 8'd1) begin bad++; $display("FAIL basic_combo got=%0d want=1", combo); end
    total++; if (n_green != 8) begin bad++; $display("FAIL basic_green_cycles got=%0d want=8", n_green); end
    total++; if (n_miss + n_stray != 0) begin bad++; $display("FAIL basic_other_pulses got=%0d want=0", n_miss + n_stray); end
  endtask

  task automatic test_miss_stray();
    int miss_at;
    do_reset();
    for (int k = 0; k < 3; k++) hit_fast();
    total++; if (combo !== 8'd3) begin bad++; $display("FAIL ms_combo_pre got=%0d want=3", combo); end
    clear_counts();
    miss_at = 0;
    for (int i = 0; i < 20; i++) begin
      zone_note = (i < 10); button = 1'b1;
      cyc();
      if (i == 10) miss_at = int'(miss_pulse);
    end
    total++; if (miss_at != 1) begin bad++; $display("FAIL ms_miss_timing got=%0d want=1", miss_at); end
    total++; if (n_miss != 1) begin bad++; $display("FAIL ms_miss_count got=%0d want=1", n_miss); end
    total++; if (combo !== 8'd0) begin bad++; $display("FAIL ms_combo_cleared got=%0d want=0", combo); end
    total++; if (n_red != 8) begin bad++; $display("FAIL ms_red_cycles got=%0d want=8", n_red); end
    clear_counts();
    for (int i = 0; i < 16; i++) begin
      zone_note = 1'b0; button = (i < 8) ? 1'b0 : 1'b1;
      cyc();
    end
    total++; if (n_stray != 1) begin bad++; $display("FAIL ms_stray_count got=%0d want=1", n_stray); end
    total++; if (score !== 16'd30) begin bad++; $display("FAIL ms_score got=%0d want=30", score); end
    total++; if (n_hit != 0) begin bad++; $display("FAIL ms_stray_hit got=%0d want=0", n_hit); end
  endtask

  task automatic test_bounce();
    int first_hit;
    do_reset();
    first_hit = -1;
    for (int i = 0; i < 40; i++) begin
      zone_note = 1'b1;
      if (i < 20) button = (((i >> 1) & 1) == 0) ? 1'b0 : 1'b1;
      else        button = (i < 30) ? 1'b0 : 1'b1;
      cyc();
      if (hit_pulse && first_hit < 0) first_hit = i;
    end
    zone_note = 1'b0;
    run(4);
    total++; if (n_hit != 1) begin bad++; $display("FAIL bounce_hits got=%0d want=1", n_hit); end
    total++; if (first_hit < 25 || first_hit > 26) begin bad++; $display("FAIL bounce_timing got=%0d want=25..26", first_hit); end
    total++; if (n_stray + n_miss != 0) begin bad++; $display("FAIL bounce_other got=%0d want=0", n_stray + n_miss); end
  endtask

  task automatic test_flash_restart();
    logic [5:0] rgb7, rgb8, rgb15, rgb16;
    do_reset();
    rgb7 = '0; rgb8 = '0; rgb15 = '0; rgb16 = '1;
    for (int i = 0; i < 26; i++) begin
      zone_note = (i < 4) || (i >= 6 && i < 18);
      button    = (i >= 2 && i < 10) ? 1'b0 : 1'b1;
      cyc();
      if (i == 7)  rgb7  = judge_rgb;
      if (i == 8)  rgb8  = judge_rgb;
      if (i == 15) rgb15 = judge_rgb;
      if (i == 16) rgb16 = judge_rgb;
    end
    total++; if (rgb7 !== 6'b110000) begin bad++; $display("FAIL flash_red got=%b want=110000", rgb7); end
    total++; if (rgb8 !== 6'b001100) begin bad++; $display("FAIL flash_replace got=%b want=001100", rgb8); end
    total++; if (rgb15 !== 6'b001100) begin bad++; $display("FAIL flash_restart_hold got=%b want=001100", rgb15); end
    total++; if (rgb16 !== 6'b000000) begin bad++; $display("FAIL flash_end got=%b want=000000", rgb16); end
    total++; if (n_red != 4 || n_green != 8) begin bad++; $display("FAIL flash_counts got=%0d/%0d want=4/8", n_red, n_green); end
    total++; if (n_multi != 0) begin bad++; $display("FAIL flash_exclusive got=%0d want=0", n_multi); end
  endtask

  task automatic test_edge_cases();
    int hit_at;
    do_reset();
    // Press while already judged
    zone_note = 1'b1; button = 1'b0; run(10);
    button = 1'b1; run(6);
    button = 1'b0; run(10);
    zone_note = 1'b0; button = 1'b1; run(8);
    total++; if (n_hit != 1 || n_stray != 0 || n_miss != 0) begin bad++; $display("FAIL edge_judged_press got=%0d/%0d/%0d want=1/0/0", n_hit, n_stray, n_miss); end
    total++; if (score !== 16'd10) begin bad++; $display("FAIL edge_judged_score got=%0d want=10", score); end
    // Press landing on the note_exit cycle
    clear_counts();
    hit_at = 0;
    for (int i = 0; i < 22; i++) begin
      zone_note = (i < 10);
      button    = (i >= 4 && i < 14) ? 1'b0 : 1'b1;
      cyc();
      if (i == 10) hit_at = int'(hit_pulse);
    end
    total++; if (hit_at != 1 || n_miss != 0) begin bad++; $display("FAIL edge_exit_press got=%0d/%0d want=1/0", hit_at, n_miss); end
    total++; if (score !== 16'd20 || combo !== 8'd2) begin bad++; $display("FAIL edge_exit_score got=%0d/%0d want=20/2", score, combo); end
    // The FSM must be idle again: a note-less press is a stray
    clear_counts();
    for (int i = 0; i < 16; i++) begin
      zone_note = 1'b0; button = (i < 8) ? 1'b0 : 1'b1;
      cyc();
    end
    total++; if (n_stray != 1 || combo !== 8'd0) begin bad++; $display("FAIL edge_idle_stray got=%0d/%0d want=1/0", n_stray, combo); end
    // Reset while armed
    zone_note = 1'b1; run(4);
    clear_counts();
    reset = 1'b1; run(3);
    total++; if (score !== 16'd0 || judge_rgb !== 6'd0) begin bad++; $display("FAIL edge_reset_clear got=%0d/%b want=0/000000", score, judge_rgb); end
    reset = 1'b0; run(4);
    total++; if (n_miss != 0) begin bad++; $display("FAIL edge_reset_nomiss got=%0d want=0", n_miss); end
    zone_note = 1'b0; run(3);
    total++; if (n_miss != 1) begin bad++; $display("FAIL edge_rearm_miss got=%0d want=1", n_miss); end
  endtask

  task automatic test_bonus_saturation();
    do_reset();
    for (int k = 0; k < 11; k++) hit_fast();
    total++; if (score !== 16'd120 || combo !== 8'd11) begin bad++; $display("FAIL bonus_11 got=%0d/%0d want=120/11", score, combo); end
    for (int k = 11; k < 300; k++) hit_fast();
    total++; if (combo !== 8'd255) begin bad++; $display("FAIL combo_sat got=%0d want=255", combo); end
    total++; if (score !== 16'd5900) begin bad++; $display("FAIL score_300 got=%0d want=5900", score); end
    for (int k = 300; k < 3281; k++) hit_fast();
    total++; if (score !== 16'd65520) begin bad++; $display("FAIL score_near_max got=%0d want=65520", score); end
    hit_fast();
    total++; if (score !== 16'd65535) begin bad++; $display("FAIL score_sat got=%0d want=65535", score); end
    hit_fast();
    total++; if (score !== 16'd65535 || combo !== 8'd255) begin bad++; $display("FAIL score_sat_hold got=%0d/%0d want=65535/255", score, combo); end
    total++; if (n_multi != 0 || n_miss != 0 || n_stray != 0) begin bad++; $display("FAIL bonus_clean got=%0d/%0d/%0d want=0/0/0", n_multi, n_miss, n_stray); end
  endtask

  initial begin
    reset = 1'b1; zone_note = 1'b0; button = 1'b1;
    clear_counts();
    test_reset();
    test_basic_hit();
    test_miss_stray();
    test_bounce();
    test_flash_restart();
    test_edge_cases();
    test_bonus_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_hit_judge.md
NOTE_HIT_JUDGE -- requirements
Module: note_hit_judge

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, cycles the synchronized button must hold a new level before it is accepted.
REQ-002 The block SHALL have parameter FLASH_CYCLES, default 6250000, cycles a judgement colour is held on judge_rgb.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port zone_note, input, 1 bit, the lane's hit-zone shift-register bit, where 1 means a note is in the zone.
REQ-006 The block SHALL have port button, input, 1 bit, the raw asynchronous player button, active-low (0 = pressed).
REQ-007 The block SHALL have port score, output, 16 bits, the accumulated score.
REQ-008 The block SHALL have port combo, output, 8 bits, the count of consecutive hits.
REQ-009 The block SHALL have ports hit_pulse, miss_pulse and stray_pulse, each an output of 1 bit, each a one-cycle event strobe.
REQ-010 The block SHALL have port judge_rgb, output, 6 bits, the feedback colour in the same 6-bit RGB format the lane uses.

Function
REQ-011 The block SHALL pass button through a 2-flop synchronizer, then a debounce counter.
- The debounced level changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any mismatch-free cycle clears the counter.
REQ-012 The block SHALL generate press as a one-cycle strobe on the debounced 1->0 transition; release generates nothing.
REQ-013 The block SHALL register zone_note as zone_prev; note_enter = zone_note & ~zone_prev; note_exit = ~zone_note & zone_prev.
REQ-014 The FSM SHALL have states IDLE, ARMED and JUDGED, with reset state IDLE.
REQ-015 In IDLE, note_enter SHALL go to ARMED. If press occurs the same cycle as note_enter, the block SHALL judge a HIT and go directly to JUDGED.
REQ-016 In IDLE, press without note_enter SHALL be a STRAY: stray_pulse=1, combo cleared, score unchanged, state unchanged.
REQ-017 In ARMED, press SHALL be a HIT and go to JUDGED. Press has priority over a same-cycle note_exit, so the block goes to IDLE instead of JUDGED in that case.
REQ-018 In ARMED, note_exit without press SHALL be a MISS: miss_pulse=1, combo cleared, go to IDLE.
REQ-019 In JUDGED, press SHALL be ignored (no pulse, no score change), and note_exit SHALL go to IDLE.
REQ-020 On HIT the block SHALL:
- assert hit_pulse=1;
- add 10 to score, plus 10 more when pre-hit combo >= 10, saturating at 65535;
- increment combo, saturating at 255.
REQ-021 Score and combo SHALL update on the clock edge following the judging cycle, with the pulse asserted in that same registered cycle (latency 1 from press/note_exit).
REQ-022 Notes SHALL be separated by at least one 0 bit in zone_note; contiguous 1s SHALL be judged as one note.
REQ-023 judge_rgb SHALL show 6'b001100 for FLASH_CYCLES cycles after hit_pulse, and 6'b110000 for FLASH_CYCLES cycles after miss_pulse or stray_pulse, otherwise 6'b000000.
REQ-024 A new event SHALL restart the flash timer and replace the colour.
REQ-025 The flash counter SHALL be wide enough for FLASH_CYCLES and SHALL NOT wrap.
REQ-026 At most one of hit_pulse, miss_pulse and stray_pulse SHALL be high in any cycle.

Reset
REQ-027 While reset=1 the block SHALL clear the following, all taking effect on the clock edge:
- score=0, combo=0;
- all pulses=0, judge_rgb=0;
- state=IDLE;
- zone_prev=0;
- debounced level=released (1), debounce and flash counters=0.
REQ-028 Reset mid-note SHALL abandon the note without a MISS. If zone_note=1 when reset deasserts, that note SHALL be re-armed via note_enter on the first cycle out of reset.
REQ-029 Synchronizer flops SHALL reset to 1 (released).

Verification (bench uses DEBOUNCE_CYCLES=4, FLASH_CYCLES=8)
REQ-030 Basic hit: zone_note high 35 cycles, button low 10 cycles starting at cycle 5 of the note -> exactly one hit_pulse; score=10, combo=1; judge_rgb=001100 for 8 cycles.
REQ-031 Miss and stray: note with no press -> miss_pulse on the cycle after zone_note falls, combo 3->0; a press with zone_note=0 -> stray_pulse, score unchanged.
REQ-032 Bounce: button toggles every 2 cycles for 20 cycles, then holds low -> exactly one press, only after 4 stable cycles.
REQ-033 Bonus and saturation: 11 consecutive hits -> score=120 (ten at 10, eleventh at 20); with score preloaded near max, score=65535 holds; 300 hits -> combo=255.
REQ-034 Edge cases:
- press during JUDGED is ignored;
- press on the exact note_exit cycle in ARMED gives a hit, not a miss;
- reset asserted in ARMED gives no miss_pulse, and the held note re-arms after reset.
